hazard_scoreboard: RTL and testbench

Parametrised hazard detection and forwarding-select unit for the pipelined MIPS core, the next generation of the fixed EXE/MEM hazard detector. It sits beside the ID stage and keeps its own shift-register record of the in-flight destinations in EXE through WB. From that record it raises `hazard_detected` and, when forwarding is enabled, drives per-source forwarding selects. It adds load-use-only stalling in forward mode, flush handling, and a saturating stall counter.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_src_match.sv | 33 +++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: the in-flight entry
// record, the register-file forwarding select and the default stage indices.
package hazard_pkg;

    // Widest register address the entry record can hold; narrower addresses are zero-extended.
    localparam int SB_DEST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 wb_en;
        logic                 mem_r_en;
    } sb_entry_t;

    localparam int FWD_REGFILE = 0;

    localparam int STG_EXE = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

endpackage

// File: rtl/hazard_src_match.sv
// Per-source comparator: flags which tracked stages will write this source
// and picks the youngest one as the forwarding select.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = STG_WB,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0]       i_src,
    input  logic                        i_used,
    input  sb_entry_t [PIPE_DEPTH:1]    i_entries,
    output logic [PIPE_DEPTH:1]         o_match,
    output logic [SEL_W-1:0]            o_sel,
    output logic                        o_load_use
);

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        o_match = '0;
        o_sel   = SEL_W'(FWD_REGFILE);
        // Walk oldest to youngest so the smallest matching stage is written last and wins.
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            o_match[k] = i_used && (i_src != '0) && i_entries[k].valid &&
                         i_entries[k].wb_en && (i_entries[k].dest == SB_DEST_W'(i_src));
            if (o_match[k]) begin
                o_sel = SEL_W'(k);
            end
        end
        o_load_use = o_match[STG_EXE] && i_entries[STG_EXE].mem_r_en;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding-select unit beside ID: a shift record of the
// destinations in EXE..WB drives stall, forwarding selects and a stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = STG_WB,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_valid,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  flush,
    output logic                  hazard_detected,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [CNT_W-1:0]      stall_cnt
);

    // WB is excluded from stall-only hazards: the register file writes before ID reads.
    localparam logic [PIPE_DEPTH:1] STALL_MASK = {1'b0, {(PIPE_DEPTH-1){1'b1}}};

    sb_entry_t [PIPE_DEPTH:1] r_entries;
    logic [CNT_W-1:0]         r_stall_cnt;

    logic [PIPE_DEPTH:1] w_match1, w_match2;
    logic [SEL_W-1:0]    w_sel1, w_sel2;
    logic                w_load_use1, w_load_use2;
    logic                w_raw;
    sb_entry_t           w_new;

    hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_src1 (
        .i_src      (id_src1),
        .i_used     (1'b1),
        .i_entries  (r_entries),
        .o_match    (w_match1),
        .o_sel      (w_sel1),
        .o_load_use (w_load_use1)
    );

    hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_src2 (
        .i_src      (id_src2),
        .i_used     (id_src2_valid),
        .i_entries  (r_entries),
        .o_match    (w_match2),
        .o_sel      (w_sel2),
        .o_load_use (w_load_use2)
    );

    assign w_raw = forward_en ? (w_load_use1 || w_load_use2)
                              : |((w_match1 | w_match2) & STALL_MASK);

    assign hazard_detected = w_raw && id_valid && !flush;
    assign fwd_sel1        = forward_en ? w_sel1 : SEL_W'(FWD_REGFILE);
    assign fwd_sel2        = forward_en ? w_sel2 : SEL_W'(FWD_REGFILE);
    assign stall_cnt       = r_stall_cnt;

    // A stalled, flushed or empty ID slot enters EXE as a bubble.
    always_comb begin
        w_new.valid    = id_valid && !flush && !hazard_detected;
        w_new.dest     = SB_DEST_W'(id_dest);
        w_new.wb_en    = id_wb_en;
        w_new.mem_r_en = id_mem_r_en;
    end

    // NOTE: state uses non-blocking assignments so every entry shifts from its pre-edge neighbour.
    // NOTE: the whole record is cleared on reset; payload could be left alone, but it is only a few flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_entries   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_entries[1] <= w_new;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                r_entries[k] <= r_entries[k-1];
            end
            if (hazard_detected && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two scoreboard configurations share one stimulus stream and
// are checked against a timestamp-based model of which instruction sits where.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst, forward_en, id_valid, id_src2_valid, id_wb_en, id_mem_r_en, flush;
    logic [4:0] id_src1, id_src2, id_dest;

    logic        hz_a, hz_b;
    logic [1:0]  sel1_a, sel2_a;
    logic [2:0]  sel1_b, sel2_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut_a (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_valid(id_src2_valid),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .hazard_detected(hz_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.PIPE_DEPTH(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_valid(id_src2_valid),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .hazard_detected(hz_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .stall_cnt(cnt_b)
    );

    typedef struct {
        bit rst, fwd, valid;
        bit [4:0] s1, s2;
        bit s2v;
        bit [4:0] dest;
        bit wb, ld, flush;
    } stim_t;

    typedef struct { bit hz; int s1; int s2; int cnt; } exp_t;
    typedef struct { bit v; int cyc; int dest; bit wb; bit ld; } rec_t;

    // Model: every accepted instruction is stamped with its ID cycle; it sits in stage k at cycle stamp+k.
    rec_t hist [2][16];
    int   depth   [2] = '{3, 4};
    int   cnt_max [2] = '{65535, 3};
    int   cnt     [2] = '{0, 0};
    int   now = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic bit producer(int i, int k, int s, bit want_load);
        int c = now - k;
        int j;
        if (c < 0 || s == 0) return 1'b0;
        j = c % 16;
        if (!hist[i][j].v || hist[i][j].cyc != c) return 1'b0;
        if (want_load) return hist[i][j].ld;
        return hist[i][j].wb && hist[i][j].dest == s;
    endfunction

    function automatic exp_t predict(int i);
        exp_t e;
        bit   raw = 1'b0;
        int   s1  = int'(id_src1);
        int   s2  = int'(id_src2);
        e.s1  = 0;
        e.s2  = 0;
        e.cnt = cnt[i];
        if (!forward_en) begin
            for (int k = 1; k < depth[i]; k++)
                if (producer(i, k, s1, 0) || (id_src2_valid && producer(i, k, s2, 0))) raw = 1'b1;
        end else begin
            raw = (producer(i, 1, s1, 0) || (id_src2_valid && producer(i, 1, s2, 0))) &&
                  producer(i, 1, 1, 1);
            for (int k = 1; k <= depth[i]; k++) begin
                if (e.s1 == 0 && producer(i, k, s1, 0)) e.s1 = k;
                if (e.s2 == 0 && id_src2_valid && producer(i, k, s2, 0)) e.s2 = k;
            end
        end
        e.hz = raw && id_valid && !flush;
        return e;
    endfunction

    task automatic model_edge();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = predict(i);
            if (!rst) begin
                for (int j = 0; j < 16; j++) hist[i][j].v = 1'b0;
                cnt[i] = 0;
            end else begin
                if (e.hz && cnt[i] < cnt_max[i]) cnt[i]++;
                if (id_valid && !flush && !e.hz)
                    hist[i][now % 16] = '{v: 1'b1, cyc: now, dest: int'(id_dest),
                                          wb: id_wb_en, ld: id_mem_r_en};
            end
        end
        now++;
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        model_edge();
        #1;
        rst           = s.rst;
        forward_en    = s.fwd;
        id_valid      = s.valid;
        id_src1       = s.s1;
        id_src2       = s.s2;
        id_src2_valid = s.s2v;
        id_dest       = s.dest;
        id_wb_en      = s.wb;
        id_mem_r_en   = s.ld;
        flush         = s.flush;
        q_a.push_back(predict(0));
        q_b.push_back(predict(1));
    endtask

    function automatic stim_t ins(bit fwd, int dest, int s1, int s2, bit s2v, bit wb, bit ld);
        stim_t s;
        s.rst = 1'b1; s.fwd = fwd; s.valid = 1'b1;
        s.s1 = 5'(s1); s.s2 = 5'(s2); s.s2v = s2v;
        s.dest = 5'(dest); s.wb = wb; s.ld = ld; s.flush = 1'b0;
        return s;
    endfunction

    function automatic stim_t nop(bit fwd);
        stim_t s = ins(fwd, 0, 0, 0, 0, 0, 0);
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst   = ($urandom_range(0, 199) != 0);
        s.fwd   = 1'($urandom_range(0, 1));
        s.valid = ($urandom_range(0, 7) != 0);
        s.s1    = 5'($urandom_range(0, 7));
        s.s2    = 5'($urandom_range(0, 7));
        s.s2v   = 1'($urandom_range(0, 1));
        s.dest  = 5'($urandom_range(0, 7));
        s.wb    = ($urandom_range(0, 4) != 0);
        s.ld    = ($urandom_range(0, 2) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever expectation the driver has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("hazard_a", 32'(hz_a), int'(e.hz));
                check("stall_cnt_a", 32'(cnt_a), e.cnt);
                if (!e.hz) begin
                    check("fwd_sel1_a", 32'(sel1_a), e.s1);
                    check("fwd_sel2_a", 32'(sel2_a), e.s2);
                end
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("hazard_b", 32'(hz_b), int'(e.hz));
                check("stall_cnt_b", 32'(cnt_b), e.cnt);
                if (!e.hz) begin
                    check("fwd_sel1_b", 32'(sel1_b), e.s1);
                    check("fwd_sel2_b", 32'(sel2_b), e.s2);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0; forward_en = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
        id_src2_valid = 1'b0; id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0; flush = 1'b0;

        // Reset held two cycles under random inputs.
        repeat (2) begin
            s = rnd();
            s.rst = 1'b0;
            apply(s);
        end

        // Stall-only back-to-back RAW on r3, done twice to push the narrow counter into saturation.
        repeat (2) begin
            apply(ins(0, 3, 1, 2, 1, 1, 0));
            repeat (4) apply(ins(0, 5, 3, 0, 0, 1, 0));
            repeat (3) apply(nop(0));
        end

        // Forwarding from EXE, then from MEM via src2.
        apply(ins(1, 3, 1, 2, 1, 1, 0));
        apply(ins(1, 6, 3, 0, 0, 1, 0));
        repeat (3) apply(nop(1));
        apply(ins(1, 3, 1, 2, 1, 1, 0));
        apply(nop(1));
        apply(ins(1, 7, 1, 3, 1, 1, 0));
        repeat (3) apply(nop(1));

        // Load-use: one stall, then forward from MEM.
        apply(ins(1, 4, 1, 2, 1, 1, 1));
        repeat (2) apply(ins(1, 8, 4, 0, 0, 1, 0));
        repeat (3) apply(nop(1));

        // Non-hazards: unused src2, r0 producer, store producer.
        apply(ins(0, 3, 1, 2, 1, 1, 0));
        apply(ins(0, 9, 1, 3, 0, 1, 0));
        repeat (3) apply(nop(0));
        apply(ins(0, 0, 1, 2, 1, 1, 0));
        apply(ins(0, 9, 0, 0, 1, 1, 0));
        repeat (3) apply(nop(0));
        apply(ins(0, 5, 1, 2, 1, 0, 0));
        apply(ins(0, 9, 5, 5, 1, 1, 0));
        repeat (3) apply(nop(0));

        // Flush wins over a pending stall.
        apply(ins(0, 3, 1, 2, 1, 1, 0));
        s = ins(0, 9, 3, 0, 0, 1, 0);
        s.flush = 1'b1;
        apply(s);
        repeat (3) apply(nop(0));

        // Reset in the middle of a stall drops the producer.
        apply(ins(0, 3, 1, 2, 1, 1, 0));
        apply(ins(0, 9, 3, 0, 0, 1, 0));
        s = ins(0, 9, 3, 0, 0, 1, 0);
        s.rst = 1'b0;
        apply(s);
        repeat (2) apply(ins(0, 9, 3, 0, 0, 1, 0));

        repeat (3000) apply(rnd());

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(q_a.size() + q_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
